// File: rtl/axi4l_seq_checker_if.sv
// AXI4-Lite write/read channel bundle for axi4l_seq_checker.
// master modport is the checker side, slave modport is the memory side.
interface axi4l_seq_checker_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axi4l_seq_checker.sv
// AXI4-Lite write-then-readback sequence checker; counts data/response errors per pass.
// Define AXI4L_SEQ_CHECKER_LFSR_EN for Galois-LFSR word data instead of an incrementing pattern.
module axi4l_seq_checker #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           NUM_WORDS   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [DATA_WIDTH-1:0] START_VALUE = 1
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                err_cnt,
  axi4l_seq_checker_if.master        m_axi
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [15:0]           LAST_K    = 16'(NUM_WORDS - 1);

`ifdef AXI4L_SEQ_CHECKER_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] LFSR_POLY = (DATA_WIDTH == 64) ?
      DATA_WIDTH'(64'hD800_0000_0000_0000) : DATA_WIDTH'(64'h0000_0000_8020_0003);
  localparam logic [DATA_WIDTH-1:0] SEED = (START_VALUE == '0) ? DATA_WIDTH'(1) : START_VALUE;

  function automatic logic [DATA_WIDTH-1:0] next_word(input logic [DATA_WIDTH-1:0] w);
    return (w >> 1) ^ (w[0] ? LFSR_POLY : '0);
  endfunction
`else
  localparam logic [DATA_WIDTH-1:0] SEED = START_VALUE;

  function automatic logic [DATA_WIDTH-1:0] next_word(input logic [DATA_WIDTH-1:0] w);
    return w + DATA_WIDTH'(1);
  endfunction
`endif

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             k_q, k_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic [15:0]             err_q, err_d;
  logic                    pass_q, pass_d;
  logic                    err_hit;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      k_q       <= '0;
      addr_q    <= BASE_ADDR;
      data_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      err_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    addr_d    = addr_q;
    data_d    = data_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    err_d     = err_q;
    pass_d    = pass_q;
    err_hit   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WR_REQ;
          k_d       = '0;
          addr_d    = BASE_ADDR;
          data_d    = SEED;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          err_d     = '0;
          pass_d    = 1'b0;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; move on once neither is still pending.
        if (m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (m_axi.M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi.M_AXI_BVALID) begin
          err_hit = (m_axi.M_AXI_BRESP != 2'b00);
          if (k_q == LAST_K) begin
            state_d   = RD_REQ;
            k_d       = '0;
            addr_d    = BASE_ADDR;
            data_d    = SEED;
            arvalid_d = 1'b1;
          end else begin
            state_d   = WR_REQ;
            k_d       = k_q + 16'd1;
            addr_d    = addr_q + ADDR_STEP;
            data_d    = next_word(data_q);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi.M_AXI_RVALID) begin
          err_hit = (m_axi.M_AXI_RDATA != data_q) || (m_axi.M_AXI_RRESP != 2'b00);
          if (k_q == LAST_K) begin
            state_d = DONE;
          end else begin
            state_d   = RD_REQ;
            k_d       = k_q + 16'd1;
            addr_d    = addr_q + ADDR_STEP;
            data_d    = next_word(data_q);
            arvalid_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        pass_d  = (err_q == '0);
      end
      default: state_d = IDLE;
    endcase

    if (err_hit && (err_q != '1)) err_d = err_q + 16'd1;
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign err_cnt = err_q;

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = data_q;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = (state_q == WR_RESP);
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = (state_q == RD_DATA);
endmodule

// File: tb/tb_axi4l_seq_checker.sv
// Bench for axi4l_seq_checker: reactive memory slaves with configurable stalls and
// error injection, a pass-level error model, and a 64-bit wrap-around instance.
`timescale 1ns/1ps
module tb_axi4l_seq_checker;
  localparam int unsigned NW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, start64 = 1'b0;
  logic busy, done, pass, busy64, done64, pass64;
  logic [15:0] err_cnt, err64;

  always #5 clk = ~clk;

  axi4l_seq_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  axi4l_seq_checker_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

  axi4l_seq_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WORDS(NW),
                      .BASE_ADDR(32'h0), .START_VALUE(32'd1)) dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .m_axi(bus.master));

  axi4l_seq_checker #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .NUM_WORDS(3),
                      .BASE_ADDR(32'h0), .START_VALUE(64'hFFFF_FFFF_FFFF_FFFF)) dut64 (
    .ACLK(clk), .ARESETN(rst_n), .start(start64), .busy(busy64), .done(done64),
    .pass(pass64), .err_cnt(err64), .m_axi(bus64.master));

  int unsigned checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- 32-bit slave: word index is taken from the address ----------------
  int unsigned cfg_aw_delay = 0, cfg_w_delay = 0;
  bit          cfg_r_stall = 0;
  logic [NW-1:0] cfg_berr = '0, cfg_rerr = '0, cfg_corrupt = '0;

  bit p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
  bit p_arvalid, p_arready, p_rvalid, p_rready;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
  bit wa_pend, wd_pend, ra_pend;
  logic [31:0] wa, wd, ra;
  int unsigned aw_cnt, w_cnt;
  int unsigned n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, proto_err = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wlog_a[$], wlog_d[$], rlog_a[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = 2'b00;
      bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RDATA = '0;
      wa_pend = 0; wd_pend = 0; ra_pend = 0; aw_cnt = 0; w_cnt = 0;
    end else begin
      aw_hs = p_awvalid && p_awready;
      w_hs  = p_wvalid && p_wready;
      b_hs  = p_bvalid && p_bready;
      ar_hs = p_arvalid && p_arready;
      r_hs  = p_rvalid && p_rready;
      if (p_awvalid && !aw_hs && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR != p_awaddr)) proto_err++;
      if (p_wvalid && !w_hs && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA != p_wdata)) proto_err++;
      if (p_arvalid && !ar_hs && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR != p_araddr)) proto_err++;
      if (aw_hs) begin bus.M_AXI_AWREADY = 1'b0; aw_cnt = 0; wa_pend = 1; wa = p_awaddr; n_aw++; end
      if (w_hs) begin
        bus.M_AXI_WREADY = 1'b0; w_cnt = 0; wd_pend = 1; wd = p_wdata; n_w++;
        if (p_wstrb != 4'hF) proto_err++;
      end
      if (b_hs) begin bus.M_AXI_BVALID = 1'b0; n_b++; end
      if (ar_hs) begin bus.M_AXI_ARREADY = 1'b0; ra_pend = 1; ra = p_araddr; n_ar++; rlog_a.push_back(p_araddr); end
      if (r_hs) begin bus.M_AXI_RVALID = 1'b0; n_r++; end

      if (bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY && !wa_pend) begin
        if (aw_cnt >= cfg_aw_delay) bus.M_AXI_AWREADY = 1'b1; else aw_cnt++;
      end
      if (bus.M_AXI_WVALID && !bus.M_AXI_WREADY && !wd_pend) begin
        if (w_cnt >= cfg_w_delay) bus.M_AXI_WREADY = 1'b1; else w_cnt++;
      end
      if (wa_pend && wd_pend && !bus.M_AXI_BVALID) begin
        mem[wa] = wd; wlog_a.push_back(wa); wlog_d.push_back(wd);
        bus.M_AXI_BVALID = 1'b1;
        bus.M_AXI_BRESP  = (wa < 32'(4*NW) && cfg_berr[wa[3:2]]) ? 2'b10 : 2'b00;
        wa_pend = 0; wd_pend = 0;
      end
      if (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY && !ra_pend && !bus.M_AXI_RVALID) begin
        if (!cfg_r_stall || $urandom_range(0, 1) == 0) bus.M_AXI_ARREADY = 1'b1;
      end
      if (ra_pend && !bus.M_AXI_RVALID) begin
        if (!cfg_r_stall || $urandom_range(0, 2) == 0) begin
          bus.M_AXI_RVALID = 1'b1;
          bus.M_AXI_RDATA  = mem.exists(ra) ? mem[ra] : 32'h0;
          if (ra < 32'(4*NW) && cfg_corrupt[ra[3:2]]) bus.M_AXI_RDATA = 32'h0;
          bus.M_AXI_RRESP  = (ra < 32'(4*NW) && cfg_rerr[ra[3:2]]) ? 2'b10 : 2'b00;
          ra_pend = 0;
        end
      end
    end
    p_awvalid = bus.M_AXI_AWVALID; p_awready = bus.M_AXI_AWREADY; p_awaddr = bus.M_AXI_AWADDR;
    p_wvalid = bus.M_AXI_WVALID; p_wready = bus.M_AXI_WREADY; p_wdata = bus.M_AXI_WDATA;
    p_wstrb = bus.M_AXI_WSTRB;
    p_bvalid = bus.M_AXI_BVALID; p_bready = bus.M_AXI_BREADY;
    p_arvalid = bus.M_AXI_ARVALID; p_arready = bus.M_AXI_ARREADY; p_araddr = bus.M_AXI_ARADDR;
    p_rvalid = bus.M_AXI_RVALID; p_rready = bus.M_AXI_RREADY;
  end

  // ---------------- 64-bit slave: always ready, never errors ----------------
  bit q_awvalid, q_wvalid, q_arvalid, q_bvalid, q_bready, q_rvalid, q_rready;
  logic [31:0] q_awaddr, q_araddr, wa2;
  logic [63:0] q_wdata, wd2;
  bit wa2_p, wd2_p;
  logic [63:0] mem64 [logic [31:0]];
  logic [31:0] w64_a[$];
  logic [63:0] w64_d[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      bus64.M_AXI_AWREADY = 1'b1; bus64.M_AXI_WREADY = 1'b1; bus64.M_AXI_ARREADY = 1'b1;
      bus64.M_AXI_BVALID = 1'b0; bus64.M_AXI_BRESP = 2'b00;
      bus64.M_AXI_RVALID = 1'b0; bus64.M_AXI_RRESP = 2'b00; bus64.M_AXI_RDATA = '0;
      wa2_p = 0; wd2_p = 0;
    end else begin
      if (q_bvalid && q_bready) bus64.M_AXI_BVALID = 1'b0;
      if (q_rvalid && q_rready) bus64.M_AXI_RVALID = 1'b0;
      if (q_awvalid) begin wa2 = q_awaddr; wa2_p = 1; end
      if (q_wvalid)  begin wd2 = q_wdata;  wd2_p = 1; end
      if (wa2_p && wd2_p) begin
        mem64[wa2] = wd2; w64_a.push_back(wa2); w64_d.push_back(wd2);
        bus64.M_AXI_BVALID = 1'b1; wa2_p = 0; wd2_p = 0;
      end
      if (q_arvalid) begin
        bus64.M_AXI_RVALID = 1'b1;
        bus64.M_AXI_RDATA  = mem64.exists(q_araddr) ? mem64[q_araddr] : 64'h0;
      end
    end
    q_awvalid = bus64.M_AXI_AWVALID; q_awaddr = bus64.M_AXI_AWADDR;
    q_wvalid = bus64.M_AXI_WVALID; q_wdata = bus64.M_AXI_WDATA;
    q_arvalid = bus64.M_AXI_ARVALID; q_araddr = bus64.M_AXI_ARADDR;
    q_bvalid = bus64.M_AXI_BVALID; q_bready = bus64.M_AXI_BREADY;
    q_rvalid = bus64.M_AXI_RVALID; q_rready = bus64.M_AXI_RREADY;
  end

  // ---------------- reference model: errors expected for one pass ----------------
  function automatic int unsigned model_err(input logic [NW-1:0] berr, input logic [NW-1:0] rerr,
                                            input logic [NW-1:0] corr);
    int unsigned e = 0;
    for (int unsigned k = 0; k < NW; k++) begin
      logic [31:0] w;
      w = 32'd1 + 32'(k);
      if (berr[k]) e++;
      if ((corr[k] && w != 32'h0) || rerr[k]) e++;
    end
    return (e > 65535) ? 65535 : e;
  endfunction

  task automatic run_pass(input string name, input int unsigned exp_err, input bit exp_pass,
                          input bit restart_mid);
    int unsigned b_aw, b_w, b_b, b_ar, b_r, b_pe, b_wl, b_rl, ndone, cyc, bad;
    b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar; b_r = n_r; b_pe = proto_err;
    b_wl = wlog_a.size(); b_rl = rlog_a.size();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({name, ".busy_after_start"}, busy, 1);
    chk({name, ".pass_cleared"}, pass, 0);
    ndone = 0; cyc = 0;
    while (ndone == 0 && cyc < 3000) begin
      @(negedge clk); cyc++;
      start = (restart_mid && cyc == 5);
      if (done) ndone++;
    end
    start = 1'b0;
    chk({name, ".done_seen"}, ndone, 1);
    chk({name, ".busy_in_done"}, busy, 1);
    @(negedge clk);
    chk({name, ".done_one_cycle"}, done, 0);
    chk({name, ".busy_after"}, busy, 0);
    chk({name, ".err_cnt"}, err_cnt, 64'(exp_err));
    chk({name, ".pass"}, pass, 64'(exp_pass));
    chk({name, ".txn_counts"}, {8'(n_aw - b_aw), 8'(n_w - b_w), 8'(n_b - b_b), 8'(n_ar - b_ar), 8'(n_r - b_r)},
        {8'(NW), 8'(NW), 8'(NW), 8'(NW), 8'(NW)});
    bad = 0;
    if (wlog_a.size() - b_wl != NW || rlog_a.size() - b_rl != NW) bad++;
    else for (int unsigned k = 0; k < NW; k++) begin
      if (wlog_a[b_wl + k] != 32'(4 * k) || wlog_d[b_wl + k] != 32'(1 + k)) bad++;
      if (rlog_a[b_rl + k] != 32'(4 * k)) bad++;
    end
    chk({name, ".addr_data_seq"}, bad, 0);
    chk({name, ".protocol"}, proto_err - b_pe, 0);
    repeat (3) @(negedge clk);
    chk({name, ".pass_held"}, pass, 64'(exp_pass));
  endtask

  typedef struct {
    string         name;
    int unsigned   aw_d, w_d;
    bit            r_stall, restart;
    logic [NW-1:0] berr, rerr, corr;
    int unsigned   exp_err;
    bit            exp_pass;
  } vec_t;

  function automatic vec_t mk(input string n, input int unsigned aw_d, input int unsigned w_d,
                              input bit rs, input bit rst_mid, input logic [NW-1:0] be,
                              input logic [NW-1:0] re, input logic [NW-1:0] co,
                              input int unsigned ee, input bit ep);
    vec_t v;
    v.name = n; v.aw_d = aw_d; v.w_d = w_d; v.r_stall = rs; v.restart = rst_mid;
    v.berr = be; v.rerr = re; v.corr = co; v.exp_err = ee; v.exp_pass = ep;
    return v;
  endfunction

  initial begin
    vec_t vecs[6];
    bit found;
    int unsigned e;
    logic [63:0] e64d[3];

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.outputs", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY,
                          bus.M_AXI_RREADY, busy, done, pass, err_cnt}, 0);
    chk("reset.outputs64", {bus64.M_AXI_AWVALID, bus64.M_AXI_WVALID, bus64.M_AXI_ARVALID, busy64,
                            done64, pass64, err64}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 64-bit data wrap: FFFF..FF, 0, 1 at stride 8
    e64d[0] = 64'hFFFF_FFFF_FFFF_FFFF; e64d[1] = 64'h0; e64d[2] = 64'h1;
    @(negedge clk); start64 = 1'b1;
    @(negedge clk); start64 = 1'b0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (done64) found = 1;
    end
    chk("w64.done_seen", found, 1);
    @(negedge clk);
    chk("w64.pass", pass64, 1);
    chk("w64.err_cnt", err64, 0);
    chk("w64.n_writes", w64_a.size(), 3);
    for (int unsigned k = 0; k < 3; k++) begin
      if (k < w64_a.size()) begin
        chk($sformatf("w64.addr%0d", k), w64_a[k], 64'(8 * k));
        chk($sformatf("w64.data%0d", k), w64_d[k], e64d[k]);
      end
    end

    vecs[0] = mk("ideal",        0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    vecs[1] = mk("corrupt_0x8",  0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100, 1, 0);
    vecs[2] = mk("all_resp_err", 0, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000, 8, 0);
    vecs[3] = mk("aw_late_rstall", 3, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    vecs[4] = mk("start_busy",   1, 2, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    vecs[5] = mk("mixed_once",   0, 1, 0, 0, 4'b0001, 4'b1000, 4'b1000, 2, 0);
    for (int i = 0; i < 6; i++) begin
      cfg_aw_delay = vecs[i].aw_d; cfg_w_delay = vecs[i].w_d; cfg_r_stall = vecs[i].r_stall;
      cfg_berr = vecs[i].berr; cfg_rerr = vecs[i].rerr; cfg_corrupt = vecs[i].corr;
      run_pass(vecs[i].name, vecs[i].exp_err, vecs[i].exp_pass, vecs[i].restart);
    end

    for (int i = 0; i < 6; i++) begin
      cfg_aw_delay = $urandom_range(0, 3); cfg_w_delay = $urandom_range(0, 3);
      cfg_r_stall = 1'($urandom); cfg_berr = NW'($urandom);
      cfg_rerr = NW'($urandom); cfg_corrupt = NW'($urandom);
      e = model_err(cfg_berr, cfg_rerr, cfg_corrupt);
      run_pass($sformatf("rand%0d", i), e, e == 0, 0);
    end

    // reset asserted while the second write waits for its response
    cfg_aw_delay = 0; cfg_w_delay = 0; cfg_r_stall = 0;
    cfg_berr = 4'b0001; cfg_rerr = '0; cfg_corrupt = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.M_AXI_BREADY && err_cnt == 16'd1) found = 1;
    end
    chk("rstmid.reached_wr2_resp", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.async_clear", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY,
                               bus.M_AXI_RREADY, busy, done, pass, err_cnt}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_berr = '0;
    @(negedge clk);
    run_pass("rstmid.fresh", 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
